// File: rtl/stream_mux_pkg.sv
// Shared definitions for the stream_mux_rr merge point: selection mode
// encodings and a width helper for channel-index fields.
package stream_mux_pkg;

  localparam logic [1:0] MODE_MANUAL = 2'b00;
  localparam logic [1:0] MODE_FIXED  = 2'b01;
  localparam logic [1:0] MODE_RR     = 2'b10;

  // Index fields are at least one bit wide even when n collapses to 1.
  function automatic int clog2_safe(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational arbiter: lowest-index-first priority, or round-robin
// starting at ptr when mode selects it. Reserved mode falls back to priority.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N    = 4,
  parameter int SELW = clog2_safe(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  input  logic [1:0]      mode,
  output logic            gnt_valid,
  output logic [SELW-1:0] gnt_idx
);

  int idx;

  // Loops run from the far end down so the last hit, i.e. the closest
  // candidate, is the one that sticks.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    if (mode == MODE_RR) begin
      for (int off = N - 1; off >= 0; off--) begin
        idx = (int'(ptr) + off) % N;
        if (req[idx]) begin
          gnt_valid = 1'b1;
          gnt_idx   = SELW'(idx);
        end
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req[i]) begin
          gnt_valid = 1'b1;
          gnt_idx   = SELW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready merge with a single registered output stage and
// manual, fixed-priority or round-robin channel selection.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int  N     = 4,
  parameter int  WIDTH = 4,
  localparam int SELW  = clog2_safe(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [N*WIDTH-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_chan
);

  logic [N-1:0]     req;
  logic             gnt_valid;
  logic [SELW-1:0]  gnt_idx;
  logic [SELW-1:0]  ptr_reg;
  logic [SELW-1:0]  ptr_next;
  logic             load_en;
  logic             transfer;
  logic [WIDTH-1:0] lane [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      assign lane[gi]     = in_data[gi*WIDTH +: WIDTH];
      assign in_ready[gi] = transfer && (gnt_idx == SELW'(gi));
    end
  endgenerate

  // Manual mode reuses the priority arbiter with only the selected request
  // left standing; an out-of-range sel leaves nothing to grant.
  always_comb begin
    req = '0;
    if (mode == MODE_MANUAL) begin
      if (int'(sel) < N) req[sel] = in_valid[sel];
    end else begin
      req = in_valid;
    end
  end

  rr_arbiter #(
    .N    (N),
    .SELW (SELW)
  ) u_arb (
    .req       (req),
    .ptr       (ptr_reg),
    .mode      (mode),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign load_en  = !out_valid || out_ready;
  assign transfer = gnt_valid && load_en;
  assign ptr_next = (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + SELW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr_reg   <= '0;
    end else begin
      if (transfer) begin
        out_valid <= 1'b1;
        out_data  <= lane[gnt_idx];
        out_chan  <= gnt_idx;
        if (mode == MODE_RR) ptr_reg <= ptr_next;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed, table-driven check of stream_mux_rr with N=4, WIDTH=4.
module tb_stream_mux_rr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [1:0]  sel = 2'b00;
  logic [3:0]  in_valid = 4'b0;
  logic [3:0]  in_ready;
  logic [15:0] in_data = 16'h3210;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_data;
  logic [1:0]  out_chan;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stream_mux_rr #(.N(4), .WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_chan  (out_chan)
  );

  typedef struct packed {
    logic [1:0]  mode;
    logic [1:0]  sel;
    logic [3:0]  valid;
    logic        ordy;
    logic [15:0] data;
    logic [3:0]  exp_rdy;
    logic        exp_ov;
    logic [3:0]  exp_d;
    logic [1:0]  exp_c;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] m, input logic [1:0] s, input logic [3:0] v,
                       input logic r, input logic [15:0] d);
    mode = m; sel = s; in_valid = v; out_ready = r; in_data = d;
  endtask

  initial begin
    //                mode   sel    valid   rdy  data      rdy_e   ov    d      c
    // manual, sel walks 0..3
    vecs.push_back('{2'b00, 2'd0, 4'b1111, 1'b1, 16'h3210, 4'b0001, 1'b1, 4'h0, 2'd0});
    vecs.push_back('{2'b00, 2'd1, 4'b1111, 1'b1, 16'h3210, 4'b0010, 1'b1, 4'h1, 2'd1});
    vecs.push_back('{2'b00, 2'd2, 4'b1111, 1'b1, 16'h3210, 4'b0100, 1'b1, 4'h2, 2'd2});
    vecs.push_back('{2'b00, 2'd3, 4'b1111, 1'b1, 16'h3210, 4'b1000, 1'b1, 4'h3, 2'd3});
    // manual on an idle channel: no grant, previous beat drains
    vecs.push_back('{2'b00, 2'd2, 4'b1011, 1'b1, 16'h3210, 4'b0000, 1'b0, 4'h3, 2'd3});
    vecs.push_back('{2'b00, 2'd2, 4'b1111, 1'b1, 16'h3210, 4'b0100, 1'b1, 4'h2, 2'd2});
    // fixed priority starves 1..3
    vecs.push_back('{2'b01, 2'd3, 4'b1111, 1'b1, 16'h3210, 4'b0001, 1'b1, 4'h0, 2'd0});
    vecs.push_back('{2'b01, 2'd3, 4'b1111, 1'b1, 16'h3210, 4'b0001, 1'b1, 4'h0, 2'd0});
    vecs.push_back('{2'b01, 2'd3, 4'b1111, 1'b1, 16'h3210, 4'b0001, 1'b1, 4'h0, 2'd0});
    vecs.push_back('{2'b01, 2'd3, 4'b1111, 1'b1, 16'h3210, 4'b0001, 1'b1, 4'h0, 2'd0});
    // round-robin from ptr=0, wrapping 3 -> 0
    vecs.push_back('{2'b10, 2'd0, 4'b1111, 1'b1, 16'h3210, 4'b0001, 1'b1, 4'h0, 2'd0});
    vecs.push_back('{2'b10, 2'd0, 4'b1111, 1'b1, 16'h3210, 4'b0010, 1'b1, 4'h1, 2'd1});
    vecs.push_back('{2'b10, 2'd0, 4'b1111, 1'b1, 16'h3210, 4'b0100, 1'b1, 4'h2, 2'd2});
    vecs.push_back('{2'b10, 2'd0, 4'b1111, 1'b1, 16'h3210, 4'b1000, 1'b1, 4'h3, 2'd3});
    vecs.push_back('{2'b10, 2'd0, 4'b1111, 1'b1, 16'h3210, 4'b0001, 1'b1, 4'h0, 2'd0});
    // ptr=1, sparse requests 1001: 3 then 0
    vecs.push_back('{2'b10, 2'd0, 4'b1001, 1'b1, 16'h3210, 4'b1000, 1'b1, 4'h3, 2'd3});
    vecs.push_back('{2'b10, 2'd0, 4'b1001, 1'b1, 16'h3210, 4'b0001, 1'b1, 4'h0, 2'd0});
    // back-pressure with new data, then release with no bubble (ptr=1)
    vecs.push_back('{2'b10, 2'd0, 4'b1111, 1'b0, 16'hFFFF, 4'b0000, 1'b1, 4'h0, 2'd0});
    vecs.push_back('{2'b10, 2'd0, 4'b1111, 1'b0, 16'hFFFF, 4'b0000, 1'b1, 4'h0, 2'd0});
    vecs.push_back('{2'b10, 2'd0, 4'b1111, 1'b1, 16'hFFFF, 4'b0010, 1'b1, 4'hF, 2'd1});
    // reserved mode acts as fixed priority
    vecs.push_back('{2'b11, 2'd0, 4'b1100, 1'b1, 16'h3210, 4'b0100, 1'b1, 4'h2, 2'd2});
    // nothing valid: output drains, data/chan hold
    vecs.push_back('{2'b11, 2'd0, 4'b0000, 1'b1, 16'h3210, 4'b0000, 1'b0, 4'h2, 2'd2});

    // Reset and check reset state
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_out_valid", 16'(out_valid), 16'h0);
    check("reset_out_data", 16'(out_data), 16'h0);
    check("reset_out_chan", 16'(out_chan), 16'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].mode, vecs[i].sel, vecs[i].valid, vecs[i].ordy, vecs[i].data);
      #1;
      check($sformatf("v%0d_in_ready", i), 16'(in_ready), 16'(vecs[i].exp_rdy));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_out_valid", i), 16'(out_valid), 16'(vecs[i].exp_ov));
      check($sformatf("v%0d_out_data", i), 16'(out_data), 16'(vecs[i].exp_d));
      check($sformatf("v%0d_out_chan", i), 16'(out_chan), 16'(vecs[i].exp_c));
      $display("vec %0d: mode=%0d valid=%b in_ready=%b out_valid=%0d out_data=%h out_chan=%0d",
               i, vecs[i].mode, vecs[i].valid, in_ready, out_valid, out_data, out_chan);
    end

    // Mid-stream reset: ptr is 2 here; load a beat in fixed mode (ptr holds),
    // then stall it and pull reset asynchronously.
    drive(2'b01, 2'd0, 4'b0010, 1'b1, 16'h3210);
    @(posedge clk);
    #1;
    check("pre_rst_out_valid", 16'(out_valid), 16'h1);
    check("pre_rst_out_chan", 16'(out_chan), 16'h1);
    $display("load before reset: out_valid=%0d out_data=%h out_chan=%0d", out_valid, out_data, out_chan);
    drive(2'b10, 2'd0, 4'b0000, 1'b0, 16'h3210);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 16'(out_valid), 16'h0);
    check("mid_rst_out_data", 16'(out_data), 16'h0);
    check("mid_rst_out_chan", 16'(out_chan), 16'h0);
    $display("async reset: out_valid=%0d out_data=%h out_chan=%0d", out_valid, out_data, out_chan);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Pointer back at 0: first round-robin grant is channel 0
    drive(2'b10, 2'd0, 4'b1111, 1'b1, 16'h3210);
    #1;
    check("post_rst_in_ready", 16'(in_ready), 16'b0001);
    @(posedge clk);
    #1;
    check("post_rst_out_valid", 16'(out_valid), 16'h1);
    check("post_rst_out_chan", 16'(out_chan), 16'h0);
    $display("after reset: out_valid=%0d out_data=%h out_chan=%0d", out_valid, out_data, out_chan);
    // and the next goes to channel 1
    #1;
    check("post_rst_in_ready2", 16'(in_ready), 16'b0010);
    @(posedge clk);
    #1;
    check("post_rst_out_chan2", 16'(out_chan), 16'h1);
    $display("next beat: out_valid=%0d out_data=%h out_chan=%0d", out_valid, out_data, out_chan);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel, WIDTH-bit multiplexer with valid/ready handshakes on every input and on the single output, a registered output stage, and three selection modes: manual select, fixed priority, and round-robin. It generalises the team's combinational 4:1 mux into a flow-controlled merge point. It sits wherever several producers share one consumer, such as a shared bus master or a debug/trace funnel.

## Interface
- N, default 4: number of input channels, ≥2.
- WIDTH, default 4: data width per channel, ≥1.
- SELW, default $clog2(N): width of the select and channel-ID fields. Derived locally, not overridden.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous assert, active-low. Single clock domain; asynchronous active-low reset.
- mode  input  2  00 manual, 01 fixed priority, 10 round-robin, 11 reserved (behaves as 01).
- sel  input  SELW  channel index used in manual mode.
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; one-hot or zero.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  consumer accepts the beat.
- out_data  output  WIDTH  registered data.
- out_chan  output  SELW  index of the channel that sourced out_data.

## Operation
- Output stage is a single register; load_en = !out_valid || out_ready.
- Grant is combinational from in_valid, mode, sel and the RR pointer:
  - manual: grant = sel when sel < N and in_valid[sel]; otherwise no grant. sel ≥ N never grants.
  - fixed: grant = lowest index i with in_valid[i].
  - round-robin: grant = first valid index at or above ptr, wrapping modulo N.
- in_ready[i] = (grant == i) && load_en. in_ready is never asserted for a channel with in_valid low.
- Input transfer on channel g, where in_valid[g] && in_ready[g]: out_data ← in_data[g], out_chan ← g, out_valid ← 1.
- Output transfer when out_valid && out_ready. If no input transfer happens in the same cycle, out_valid ← 0. Simultaneous output and input transfer is full throughput: one beat per cycle, no bubble.
- RR pointer updates only on an input transfer in round-robin mode: ptr ← (g+1) mod N, with N-1 wrapping to 0. In other modes the pointer holds.
- A mode or sel change takes effect combinationally for the next grant. A beat already in the output register is unaffected.
- out_data and out_chan hold their value while out_valid && !out_ready. A stalled beat is never overwritten.
- No data is dropped or duplicated. Each input beat appears exactly once at the output, in acceptance order.

## Timing
- Reset values: out_valid=0, out_data=0, out_chan=0, ptr=0. in_ready is then valid as soon as in_valid is, since load_en=1.
- Latency is 1 cycle: a beat accepted at edge k is presented on out_* after edge k, with out_valid high during cycle k+1.
- in_ready depends combinationally on out_ready. out_* never depend combinationally on in_*.
- Reset asserted mid-stream clears out_valid immediately, so an in-flight beat is discarded, and returns ptr to 0.
- Sustained throughput is 1 beat/cycle while out_ready=1 and some granted input is valid.

## Structure
- Shared package stream_mux_pkg holds:
  - mode constants MODE_MANUAL=2'b00, MODE_FIXED=2'b01, MODE_RR=2'b10;
  - a clog2-safe helper so that SELW ≥ 1.
- Sub-module rr_arbiter (N, SELW) takes req[N], ptr and mode, and returns gnt_valid and gnt_idx. It is combinational.
- Pointer register, output register and handshake logic live in the top.

## Test plan
For all scenarios, N=4, WIDTH=4, in_data = {d=3, c=2, b=1, a=0}.
- Reset, then all valid, mode=00, sel=0..3 in turn, out_ready=1:
  - out_data = 0, 1, 2, 3 one cycle after each accept;
  - out_chan = sel;
  - in_ready is one-hot on sel.
- Manual mode, sel=2, in_valid=4'b1011: in_ready=0 and out_valid stays 0. Then raise in_valid[2]: out_data=2 on the next cycle.
- Fixed mode, all four valid, out_ready=1 for 4 cycles: out_chan=0 every cycle, and channels 1-3 are starved.
- Round-robin mode, all four valid, out_ready=1: out_chan sequence 0,1,2,3,0, with wrap from 3 back to 0. Then in_valid=4'b1001 with ptr at 1: grant 3, then 0.
- Back-pressure: out_ready=0 with a beat held, in_data changed to 4'hF:
  - out_data stays unchanged and all in_ready=0;
  - then out_ready=1 for one cycle: the held beat completes and the new beat loads the same cycle with no bubble.
- Reset mid-stream, with out_valid=1 and ptr=2: rst_n low for one cycle gives out_valid=0, out_data=0 and out_chan=0 immediately. After release in round-robin mode, the first grant goes to channel 0.
